// File: rtl/fetch_issue.sv
// Instruction fetch-and-issue stage: assembles one- and two-byte instructions from
// combinational program memory and issues registered opcode/operand pairs.
// Optional feature: define FETCH_FLUSH2_EN to issue two bubbles after a redirect.
module fetch_issue #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] pm_addr,
    input  logic [7:0] pm_data,
    input  logic       stall,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    output logic [7:0] opcode_out,
    output logic [7:0] operand_out,
    output logic       issue_valid,
    output logic [7:0] ret_pc
);

    localparam logic [1:0] S_OP    = 2'd0;
    localparam logic [1:0] S_OD    = 2'd1;
`ifdef FETCH_FLUSH2_EN
    localparam logic [1:0] S_FLUSH = 2'd2;
`endif

    // Opcodes that carry a trailing operand byte.
    function automatic logic is_two_byte(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        if ((op == 8'h03) || (op == 8'h05)) begin
            hit = 1'b1;
        end else begin
            case (op[7:3])
                5'b00001, 5'b00110, 5'b01011, 5'b10001,
                5'b10011, 5'b10101, 5'b10111, 5'b11001,
                5'b11011, 5'b11101: hit = 1'b1;
                default:            hit = 1'b0;
            endcase
        end
        return hit;
    endfunction

    logic [1:0] state_r;
    logic [7:0] pc_r;
    logic [7:0] ir_r;
    logic [7:0] opcode_r;
    logic [7:0] operand_r;
    logic       valid_r;
    logic [7:0] ret_pc_r;

    logic [1:0] state_s;
    logic [7:0] pc_s;
    logic [7:0] ir_s;
    logic [7:0] opcode_s;
    logic [7:0] operand_s;
    logic       valid_s;
    logic [7:0] ret_pc_s;
    logic [7:0] pc_inc_s;
    logic       two_byte_s;

    assign pc_inc_s   = pc_r + 8'd1;
    assign two_byte_s = is_two_byte(pm_data);

    // Next-state and issue logic: redirect beats stall beats normal fetch.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ir_s      = ir_r;
        opcode_s  = opcode_r;
        operand_s = operand_r;
        valid_s   = valid_r;
        ret_pc_s  = ret_pc_r;
        if (redirect) begin
            pc_s      = redirect_pc;
            ir_s      = 8'h00;
            opcode_s  = 8'h00;
            operand_s = 8'h00;
            valid_s   = 1'b0;
`ifdef FETCH_FLUSH2_EN
            state_s   = S_FLUSH;
`else
            state_s   = S_OP;
`endif
        end else if (stall) begin
            state_s = state_r;
        end else begin
            case (state_r)
                S_OP: begin
                    pc_s = pc_inc_s;
                    if (two_byte_s) begin
                        ir_s      = pm_data;
                        opcode_s  = 8'h00;
                        operand_s = 8'h00;
                        valid_s   = 1'b0;
                        state_s   = S_OD;
                    end else begin
                        opcode_s  = pm_data;
                        operand_s = 8'h00;
                        valid_s   = 1'b1;
                        ret_pc_s  = pc_inc_s;
                        state_s   = S_OP;
                    end
                end
                S_OD: begin
                    opcode_s  = ir_r;
                    operand_s = pm_data;
                    valid_s   = 1'b1;
                    ret_pc_s  = pc_inc_s;
                    pc_s      = pc_inc_s;
                    state_s   = S_OP;
                end
`ifdef FETCH_FLUSH2_EN
                S_FLUSH: begin
                    opcode_s  = 8'h00;
                    operand_s = 8'h00;
                    valid_s   = 1'b0;
                    state_s   = S_OP;
                end
`endif
                default: begin
                    opcode_s  = 8'h00;
                    operand_s = 8'h00;
                    valid_s   = 1'b0;
                    state_s   = S_OP;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_OP;
            pc_r      <= RESET_PC;
            ir_r      <= 8'h00;
            opcode_r  <= 8'h00;
            operand_r <= 8'h00;
            valid_r   <= 1'b0;
            ret_pc_r  <= 8'h00;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            ir_r      <= ir_s;
            opcode_r  <= opcode_s;
            operand_r <= operand_s;
            valid_r   <= valid_s;
            ret_pc_r  <= ret_pc_s;
        end
    end

    assign pm_addr     = pc_r;
    assign opcode_out  = opcode_r;
    assign operand_out = operand_r;
    assign issue_valid = valid_r;
    assign ret_pc      = ret_pc_r;

endmodule

// File: tb/tb_fetch_issue.sv
// Self-checking bench for fetch_issue: directed scenarios plus randomized traffic
// compared against a behavioural fetch model.
module tb_fetch_issue;

    logic       clk;
    logic       rst_n;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] opcode_out;
    logic [7:0] operand_out;
    logic       issue_valid;
    logic [7:0] ret_pc;

    logic [7:0] mem [256];

    int checks;
    int errors;

    // Model state
    logic [7:0] m_pc;
    bit         m_pend;
    logic [7:0] m_pend_op;
    int         m_flush;
    logic [7:0] e_op, e_opd, e_ret;
    logic       e_v;

    fetch_issue #(.RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pm_addr     (pm_addr),
        .pm_data     (pm_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .opcode_out  (opcode_out),
        .operand_out (operand_out),
        .issue_valid (issue_valid),
        .ret_pc      (ret_pc)
    );

    assign pm_data = mem[pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit has_operand(input logic [7:0] b);
        return (b == 8'h03) || (b == 8'h05) ||
               (b >= 8'h08 && b <= 8'h0F) || (b >= 8'h30 && b <= 8'h37) ||
               (b >= 8'h58 && b <= 8'h5F) || (b >= 8'h88 && b <= 8'h8F) ||
               (b >= 8'h98 && b <= 8'h9F) || (b >= 8'hA8 && b <= 8'hAF) ||
               (b >= 8'hB8 && b <= 8'hBF) || (b >= 8'hC8 && b <= 8'hCF) ||
               (b >= 8'hD8 && b <= 8'hDF) || (b >= 8'hE8 && b <= 8'hEF);
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bubble();
        e_op  = 8'h00;
        e_opd = 8'h00;
        e_v   = 1'b0;
    endtask

    // Advance the model by one edge using the currently driven inputs, then compare.
    task automatic step();
        logic [7:0] b;
        if (!rst_n) begin
            m_pc = 8'h00; m_pend = 0; m_flush = 0;
            bubble(); e_ret = 8'h00;
        end else if (redirect) begin
            m_pc = redirect_pc; m_pend = 0;
`ifdef FETCH_FLUSH2_EN
            m_flush = 1;
`else
            m_flush = 0;
`endif
            bubble();
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_flush > 0) begin
            m_flush--;
            bubble();
        end else if (m_pend) begin
            e_op = m_pend_op; e_opd = mem[m_pc]; e_v = 1'b1;
            e_ret = m_pc + 8'd1; m_pc = m_pc + 8'd1; m_pend = 0;
        end else begin
            b = mem[m_pc];
            if (has_operand(b)) begin
                m_pend = 1; m_pend_op = b; m_pc = m_pc + 8'd1;
                bubble();
            end else begin
                e_op = b; e_opd = 8'h00; e_v = 1'b1;
                e_ret = m_pc + 8'd1; m_pc = m_pc + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        check("pm_addr", pm_addr, m_pc);
        check("opcode", opcode_out, e_op);
        check("operand", operand_out, e_opd);
        check("valid", {7'd0, issue_valid}, {7'd0, e_v});
        check("ret_pc", ret_pc, e_ret);
    endtask

    task automatic go(input logic r, input logic s, input logic rd, input logic [7:0] rpc);
        rst_n = r; stall = s; redirect = rd; redirect_pc = rpc;
        step();
    endtask

    // Redirect plus any flush bubbles so the next step fetches at target.
    task automatic jump_to(input logic [7:0] target);
        go(1'b1, 1'b0, 1'b1, target);
`ifdef FETCH_FLUSH2_EN
        go(1'b1, 1'b0, 1'b0, 8'h00);
`endif
    endtask

    initial begin
        checks = 0; errors = 0;
        m_pc = 8'h00; m_pend = 0; m_pend_op = 8'h00; m_flush = 0;
        e_op = 8'h00; e_opd = 8'h00; e_v = 1'b0; e_ret = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

        // Reset, then first one-byte issue
        mem[8'h00] = 8'h41;
        go(1'b0, 1'b0, 1'b0, 8'h00);
        go(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_opcode", opcode_out, 8'h00);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        check("first_issue", opcode_out, 8'h41);
        check("first_ret", ret_pc, 8'h01);

        // Two-byte instruction after reset
        mem[8'h00] = 8'h8A; mem[8'h01] = 8'h3C; mem[8'h02] = 8'h00;
        go(1'b0, 1'b0, 1'b0, 8'h00);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        check("tb_operand", operand_out, 8'h3C);
        go(1'b1, 1'b0, 1'b0, 8'h00);

        // Redirect while operand pending
        mem[8'h10] = 8'h05; mem[8'h11] = 8'h77; mem[8'h40] = 8'h12;
        jump_to(8'h10);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        go(1'b1, 1'b0, 1'b1, 8'h40);
        check("redir_addr", pm_addr, 8'h40);
`ifdef FETCH_FLUSH2_EN
        go(1'b1, 1'b0, 1'b0, 8'h00);
`endif
        go(1'b1, 1'b0, 1'b0, 8'h00);
        check("redir_issue", opcode_out, 8'h12);

        // Stall holding an issued instruction, then stall+redirect
        mem[8'h05] = 8'h20;
        jump_to(8'h05);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) go(1'b1, 1'b1, 1'b0, 8'h00);
        check("stall_addr", pm_addr, 8'h06);
        go(1'b1, 1'b1, 1'b1, 8'h40);
        check("stall_redir", pm_addr, 8'h40);

        // Stall mid two-byte fetch
        mem[8'h20] = 8'h33; mem[8'h21] = 8'h99;
        jump_to(8'h20);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        go(1'b1, 1'b1, 1'b0, 8'h00);
        go(1'b1, 1'b1, 1'b0, 8'h00);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        check("stall_od_op", opcode_out, 8'h33);

        // PC wrap with operand at address 0
        mem[8'hFF] = 8'hC9; mem[8'h00] = 8'h0F;
        jump_to(8'hFF);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        check("wrap_op", opcode_out, 8'hC9);
        check("wrap_ret", ret_pc, 8'h01);

        // Reset while operand pending
        jump_to(8'hFF);
        go(1'b1, 1'b0, 1'b0, 8'h00);
        go(1'b0, 1'b0, 1'b0, 8'h00);
        check("mid_rst_addr", pm_addr, 8'h00);
        go(1'b1, 1'b0, 1'b0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            if ((n % 97) == 0) mem[$urandom_range(0, 255)] = 8'($urandom);
            go(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
               8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
